// File: rtl/wb_arbiter.sv
// Two-master round-robin arbiter for the internal 8-bit register bus.
// Routes one single-beat transfer at a time and ends stalled transfers with an error.
module wb_arbiter #(
    parameter int TIMEOUT = 64,
    parameter int TW      = 8
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       m0_stb_i,
    input  logic       m0_we_i,
    input  logic [7:0] m0_adr_i,
    input  logic [7:0] m0_dat_i,
    output logic       m0_ack_o,
    output logic       m0_err_o,
    output logic [7:0] m0_dat_o,
    output logic       m0_gnt_o,
    input  logic       m1_stb_i,
    input  logic       m1_we_i,
    input  logic [7:0] m1_adr_i,
    input  logic [7:0] m1_dat_i,
    output logic       m1_ack_o,
    output logic       m1_err_o,
    output logic [7:0] m1_dat_o,
    output logic       m1_gnt_o,
    output logic       stb_o,
    output logic       we_o,
    output logic [7:0] adr_o,
    output logic [7:0] dat_o,
    input  logic       ack_i,
    input  logic [7:0] dat_i
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    localparam bit            TO_EN    = (TIMEOUT != 0);
    localparam logic [TW-1:0] CNT_LAST = TW'(TIMEOUT - 1);

    state_t        state_reg, state_next;
    logic          last_reg, last_next;
    logic [TW-1:0] cnt_reg, cnt_next;

    logic          granted;
    logic [1:0]    gnt_vec;
    logic          cur_stb, cur_we;
    logic [7:0]    cur_adr, cur_dat;
    logic          timeout_hit;
    logic          term_ack;
    logic [7:0]    rdat;
    logic [1:0]    ack_vec, err_vec;
    logic [7:0]    rdat_vec [2];

    // Everything below is decoded from the registered state, so an async
    // reset forces every output low without waiting for an edge.
    assign gnt_vec = {state_reg == GNT1, state_reg == GNT0};
    assign granted = |gnt_vec;

    assign cur_stb = gnt_vec[1] ? m1_stb_i : m0_stb_i;
    assign cur_we  = gnt_vec[1] ? m1_we_i  : m0_we_i;
    assign cur_adr = gnt_vec[1] ? m1_adr_i : m0_adr_i;
    assign cur_dat = gnt_vec[1] ? m1_dat_i : m0_dat_i;

    // A slave ack in the timeout cycle wins; an abort suppresses the error.
    assign timeout_hit = TO_EN && granted && cur_stb && !ack_i && (cnt_reg == CNT_LAST);
    assign term_ack    = granted && (ack_i || timeout_hit);
    assign rdat        = ack_i ? dat_i : 8'hFF;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_master
            assign ack_vec[gi]  = gnt_vec[gi] & term_ack;
            assign err_vec[gi]  = gnt_vec[gi] & timeout_hit;
            assign rdat_vec[gi] = (gnt_vec[gi] & term_ack) ? rdat : 8'h00;
        end
    endgenerate

    assign m0_gnt_o = gnt_vec[0];
    assign m0_ack_o = ack_vec[0];
    assign m0_err_o = err_vec[0];
    assign m0_dat_o = rdat_vec[0];
    assign m1_gnt_o = gnt_vec[1];
    assign m1_ack_o = ack_vec[1];
    assign m1_err_o = err_vec[1];
    assign m1_dat_o = rdat_vec[1];

    assign stb_o = granted ? cur_stb : 1'b0;
    assign we_o  = granted ? cur_we  : 1'b0;
    assign adr_o = granted ? cur_adr : 8'h00;
    assign dat_o = granted ? cur_dat : 8'h00;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg <= IDLE;
            last_reg  <= 1'b1;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            last_reg  <= last_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        last_next  = last_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE: begin
                // On a tie the master that was not granted last goes first.
                if (m0_stb_i && (!m1_stb_i || last_reg)) begin
                    state_next = GNT0;
                    last_next  = 1'b0;
                    cnt_next   = '0;
                end else if (m1_stb_i) begin
                    state_next = GNT1;
                    last_next  = 1'b1;
                    cnt_next   = '0;
                end
            end
            GNT0, GNT1: begin
                if (!cur_stb || ack_i || timeout_hit) begin
                    state_next = IDLE;
                end else if (cnt_reg != '1) begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule
